avmm_csr_responder: RTL

Avalon-MM responder (agent-side counterpart of the avmm host driver) exposing a small control/status register bank, a free-running counter and a push/pop data FIFO on the 8-bit-address, 32-bit-data avmm bus. It is the DUT the avmm agent drives: it accepts single-cycle `write`/`read` strobes and returns `readdata` with a fixed one-cycle latency. There is no waitrequest and no readdatavalid.

---
 rtl/avmm_csr_responder_pkg.sv | 39 +++
 rtl/avmm_csr_responder_if.sv | 19 +
 rtl/avmm_csr_responder_fifo.sv | 68 ++++++
 rtl/avmm_csr_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/avmm_csr_responder_pkg.sv
// Shared constants and types for the avmm CSR responder: register map,
// field positions and the CTRL register layout.
package avmm_pkg;

  localparam logic [7:0] ADDR_ID      = 8'h00;
  localparam logic [7:0] ADDR_CTRL    = 8'h01;
  localparam logic [7:0] ADDR_STATUS  = 8'h02;
  localparam logic [7:0] ADDR_SCRATCH = 8'h03;
  localparam logic [7:0] ADDR_COUNTER = 8'h04;
  localparam logic [7:0] ADDR_FIFO    = 8'h05;

  localparam logic [31:0] ID_VALUE = 32'hA5A5_0001;

  localparam int CTRL_CNT_EN   = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_FIFO_CLR = 2;

  localparam int STATUS_EMPTY     = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_LEVEL_LSB = 8;
  localparam int STATUS_LEVEL_W   = 5;
  localparam int STATUS_OVF       = 16;
  localparam int STATUS_UDF       = 17;

  // fifo_clr is a write-1 pulse, so only the persistent bits live here
  typedef struct packed {
    logic irq_en;
    logic cnt_en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_CNT_EN] = c.cnt_en;
    w[CTRL_IRQ_EN] = c.irq_en;
    return w;
  endfunction

endpackage

// File: rtl/avmm_csr_responder_if.sv
// Avalon-MM bus bundle: 8-bit word address, 32-bit data, one-cycle read latency.
interface avmm_csr_responder_if;
  logic [7:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, write, read, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, write, read, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/avmm_csr_responder_fifo.sv
// Synchronous FIFO with registered storage and combinational head output.
// Push when full and pop when empty are silently ignored here.
module avmm_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign level   = count;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Depth is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR responder: ID/CTRL/STATUS/SCRATCH/COUNTER registers plus a
// push/pop data FIFO, fixed one-cycle read latency, level interrupt.
import avmm_pkg::*;

module avmm_csr_responder #(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  avmm_csr_responder_if.slave  bus
);

  localparam int FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FIFO_LW = FIFO_AW + 1;

  ctrl_t        ctrl;
  logic [31:0]  scratch;
  logic [31:0]  counter;
  logic         ovf;
  logic         udf;
  logic [31:0]  readdata_q;

  logic         wr_en;
  logic         rd_en;
  logic         wr_ctrl;
  logic         wr_status;
  logic         wr_scratch;
  logic         wr_counter;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_clr;
  logic         ovf_set;
  logic         udf_set;
  logic [31:0]  fifo_dout;
  logic [FIFO_LW-1:0] fifo_level;
  logic         fifo_empty;
  logic         fifo_full;
  logic [31:0]  status_word;
  logic [31:0]  rd_mux;

  // A write takes priority; a read in the same cycle is dropped entirely
  assign wr_en      = bus.write;
  assign rd_en      = bus.read & ~bus.write;
  assign wr_ctrl    = wr_en && (bus.address == ADDR_CTRL);
  assign wr_status  = wr_en && (bus.address == ADDR_STATUS);
  assign wr_scratch = wr_en && (bus.address == ADDR_SCRATCH);
  assign wr_counter = wr_en && (bus.address == ADDR_COUNTER);
  assign fifo_push  = wr_en && (bus.address == ADDR_FIFO);
  assign fifo_pop   = rd_en && (bus.address == ADDR_FIFO);
  assign fifo_clr   = wr_ctrl & bus.writedata[CTRL_FIFO_CLR];
  assign ovf_set    = fifo_push & fifo_full;
  assign udf_set    = fifo_pop & fifo_empty;

  avmm_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clr   (fifo_clr),
    .din   (bus.writedata),
    .dout  (fifo_dout),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    status_word = '0;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = STATUS_LEVEL_W'(fifo_level);
    status_word[STATUS_OVF]   = ovf;
    status_word[STATUS_UDF]   = udf;
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_ID:      rd_mux = ID_VALUE;
      ADDR_CTRL:    rd_mux = ctrl_word(ctrl);
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_SCRATCH: rd_mux = scratch;
      ADDR_COUNTER: rd_mux = counter;
      ADDR_FIFO:    rd_mux = fifo_empty ? 32'h0 : fifo_dout;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      scratch <= SCRATCH_RESET;
    end else begin
      if (wr_ctrl) begin
        ctrl.cnt_en <= bus.writedata[CTRL_CNT_EN];
        ctrl.irq_en <= bus.writedata[CTRL_IRQ_EN];
      end
      if (wr_scratch) begin
        scratch <= bus.writedata;
      end
    end
  end

  // A load wins over the increment in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (wr_counter) begin
      counter <= bus.writedata;
    end else if (ctrl.cnt_en) begin
      counter <= counter + 32'd1;
    end
  end

  // Sticky flags: a set in the same cycle as its W1C keeps the flag high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set | (ovf & ~(wr_status & bus.writedata[STATUS_OVF]));
      udf <= udf_set | (udf & ~(wr_status & bus.writedata[STATUS_UDF]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= '0;
    end else if (rd_en) begin
      readdata_q <= rd_mux;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = ctrl.irq_en & (ovf | udf);

endmodule
